comp_seq_ctrl: RTL and testbench

COMP_SEQ_CTRL -- requirements
Module: comp_seq_ctrl

---
 rtl/comp_seq_pkg.sv | 23 ++
 rtl/comp_2bit.sv | 22 ++
 rtl/comp_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_comp_seq_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/comp_seq_pkg.sv
// ---------------------------------------------------------------------------
// comp_seq_pkg
// Shared definitions for the sequential 2-bit-per-cycle magnitude comparator.
//   state_t        : controller state encoding (IDLE/RUN/DONE)
//   WIDTH_DEFAULT  : default operand width in bits
// ---------------------------------------------------------------------------
package comp_seq_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index register width for a given operand width; kept at least 1 bit so
  // the WIDTH=2 case (a single slice) still has a legal vector.
  function automatic int idx_width(input int width);
    return (width > 2) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/comp_2bit.sv
// ---------------------------------------------------------------------------
// comp_2bit
// Purely combinational 2-bit unsigned magnitude comparator slice.
//   a[1:0], b[1:0] : operand slices
//   l              : a <  b
//   e              : a == b
//   g              : a >  b
// Exactly one of l/e/g is high for any input.
// ---------------------------------------------------------------------------
module comp_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       l,
  output logic       e,
  output logic       g
);

  assign l = (a <  b);
  assign e = (a == b);
  assign g = (a >  b);

endmodule

// File: rtl/comp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// comp_seq_ctrl
// Sequential unsigned magnitude comparator. Operands captured on an accepted
// start are compared MSB-first, two bits per cycle, through a single shared
// comp_2bit slice. The first unequal slice decides the result immediately;
// if every slice matches the operands are equal.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : compare request, only honoured in IDLE
//   a, b   : operands (WIDTH bits, WIDTH even and >= 2)
//   busy   : high while in RUN or DONE
//   done   : one-cycle pulse, results valid
//   l/e/g  : registered A<B / A==B / A>B, held until the next done
// ---------------------------------------------------------------------------
module comp_seq_ctrl
  import comp_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int IDXW   = idx_width(WIDTH);
  localparam int NSLICE = WIDTH / 2;

  state_t             r_state;
  logic [IDXW-1:0]    r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_busy;
  logic               r_done;
  logic               r_l;
  logic               r_e;
  logic               r_g;

  logic [1:0]         w_a_sl;
  logic [1:0]         w_b_sl;
  logic               w_l;
  logic               w_e;
  logic               w_g;

  // Pick the 2-bit slice addressed by idx; out-of-range indices (only
  // possible for non power-of-two slice counts) read as zero.
  function automatic logic [1:0] slice_of(input logic [WIDTH-1:0] v,
                                          input logic [IDXW-1:0]  idx);
    logic [1:0] res;
    res = 2'b00;
    for (int i = 0; i < NSLICE; i++) begin
      res = (idx == IDXW'(i)) ? v[2*i +: 2] : res;
    end
    return res;
  endfunction

  // Slice-select mux feeding the shared comparator from the captured operands.
  always_comb begin
    w_a_sl = slice_of(r_a, r_idx);
    w_b_sl = slice_of(r_b, r_idx);
  end

  comp_2bit u_slice (
    .a (w_a_sl),
    .b (w_b_sl),
    .l (w_l),
    .e (w_e),
    .g (w_g)
  );

  // Controller FSM with operand capture, slice index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= IDXW'(NSLICE - 1);
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!w_e) begin
            // First unequal slice decides; slice outputs are already one-hot.
            {r_l, r_e, r_g} <= {w_l, w_e, w_g};
            r_done          <= 1'b1;
            r_state         <= ST_DONE;
          end else if (r_idx == IDXW'(0)) begin
            {r_l, r_e, r_g} <= 3'b010;
            r_done          <= 1'b1;
            r_state         <= ST_DONE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here: requests during DONE
          // are dropped rather than queued.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign l    = r_l;
  assign e    = r_e;
  assign g    = r_g;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comp_seq_ctrl
// Self-checking bench for comp_seq_ctrl (WIDTH=8): directed scenarios plus
// randomized compares scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_comp_seq_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         l;
  logic         e;
  logic         g;

  int           total = 0;
  int           bad   = 0;
  logic [2:0]   held  = 3'b000;

  always #5 clk = ~clk;

  comp_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .l     (l),
    .e     (e),
    .g     (g)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slices examined: every slice above the highest differing bit's slice
  // matches, so the compare stops at that slice (or runs all slices).
  function automatic int model_k(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    int msb;
    d   = x ^ y;
    msb = -1;
    for (int i = 0; i < W; i++) if (d[i]) msb = i;
    if (msb < 0) return NS;
    return NS - msb / 2;
  endfunction

  function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x < y)  return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // One full compare; spam keeps start high through busy, wiggle scrambles
  // a/b after acceptance.
  task automatic do_compare(input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input bit spam, input bit wiggle, input string nm);
    int         k;
    logic [2:0] er;
    bit         seen;
    k  = model_k(xa, xb);
    er = model_res(xa, xb);
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    if (!spam) start = 1'b0;
    chk({nm, "_busy_acc"}, {31'd0, busy}, 32'd1);
    chk({nm, "_done_acc"}, {31'd0, done}, 32'd0);
    seen = 1'b0;
    for (int c = 1; c <= NS + 2 && !seen; c++) begin
      if (wiggle) begin a = W'($urandom); b = W'($urandom); end
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        chk({nm, "_latency"}, c + 1, k + 1);
        chk({nm, "_result"}, {29'd0, l, e, g}, {29'd0, er});
        chk({nm, "_busy_done"}, {31'd0, busy}, 32'd1);
        held = er;
      end else begin
        chk({nm, "_hold_run"}, {29'd0, l, e, g}, {29'd0, held});
        chk({nm, "_busy_run"}, {31'd0, busy}, 32'd1);
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_hold_idle"}, {29'd0, l, e, g}, {29'd0, held});
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_out", {27'd0, busy, done, l, e, g}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: equal operands, all slices examined
    do_compare(8'hA5, 8'hA5, 1'b0, 1'b0, "s1");
    // Scenario 2: top slice decides
    do_compare(8'h80, 8'h7F, 1'b0, 1'b0, "s2");
    // Scenario 3: last slice decides, then results hold while inputs toggle
    do_compare(8'h34, 8'h36, 1'b0, 1'b1, "s3");
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("s3_hold_toggle", {28'd0, busy, l, e, g}, {28'd0, 1'b0, held});
    end

    // Scenario 4: start held through busy gives a single compare only
    do_compare(8'h12, 8'h13, 1'b1, 1'b0, "s4");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("s4_no_queue", {30'd0, busy, done}, 32'd0);
    end
    do_compare(8'hC3, 8'hC3, 1'b0, 1'b0, "s4_next");

    // Randomized compares biased toward equal and near-equal operands
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           mode;
      ra   = W'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0)      rb = W'($urandom);
      else if (mode == 1) rb = ra;
      else                rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      do_compare(ra, rb, 1'b0, bit'($urandom_range(0, 1)), "rnd");
    end

    // Scenario 5: reset mid-RUN aborts with no done pulse
    @(negedge clk);
    a = 8'h55; b = 8'h56; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("s5_rst_out", {27'd0, busy, done, l, e, g}, 32'd0);
    held = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NS + 3; i++) begin
      @(posedge clk); #1;
      chk("s5_no_done", {30'd0, busy, done}, 32'd0);
    end
    do_compare(8'hFF, 8'h00, 1'b0, 1'b0, "s5_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
